seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
- Serial bit-pattern transmitter: the stimulus/transmit end of the team's serial sequence detectors.
- Loads a PAT_W-bit pattern and a repeat count, then shifts the pattern out MSB-first, one bit per accepted transfer.
- An optional idle gap of zero bits separates frames so that back-to-back frames cannot form overlapping matches at a downstream detector.
- Drives the detector's `din` directly, or through a ready-gated link.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- CNT_W, 8, width of the repeat-count and frame-count fields.
- GAP_W, 3, width of the gap-length field.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-low reset; all state clears on a clk edge where reset==0.
- start  input  1  request to begin a burst; sampled only in IDLE.
- abort  input  1  terminates the burst; effective in any non-IDLE state.
- pattern  input  PAT_W  pattern to send; latched on start.
- reps  input  CNT_W  number of frames to send; latched on start.
- gap_len  input  GAP_W  zero-bit cycles inserted between frames; latched on start; 0 means no gap.
- dout  output  1  serial data bit.
- dout_valid  output  1  dout is meaningful this cycle.
- dout_ready  input  1  downstream accepts the bit; a transfer occurs when dout_valid && dout_ready.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a burst completes normally.
- frame_cnt  output  CNT_W  number of frames fully sent in the current or last burst.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - dout=0, dout_valid=0, busy=0, done=0, frame_cnt=0.
  - Shift register, bit index and gap counter clear.
- All outputs are registered; no combinational path from any input to any output.

FSM states and transitions:
- IDLE: dout_valid=0, dout=0.
  - start=1 and reps!=0: latch pattern, reps and gap_len; clear frame_cnt; go to SHIFT.
  - start=1 and reps==0: go to DONE with no bits sent.
- SHIFT: dout_valid=1, dout = shift register MSB.
  - On a transfer, shift left and increment the bit index.
  - dout_ready=0: hold dout and dout_valid, no advance.
  - Transfer of bit index PAT_W-1: increment frame_cnt.
    - frame_cnt+1==reps: go to DONE.
    - Else gap_len!=0: go to GAP.
    - Else reload the pattern and stay in SHIFT, giving back-to-back frames with no bubble.
- GAP: dout_valid=1, dout=0.
  - Each transfer decrements the gap counter, which is loaded with gap_len on entry.
  - The transfer that takes the counter to 0 reloads the pattern and goes to SHIFT.
  - Stalls under dout_ready=0 in the same way as SHIFT.
- DONE: done=1 and dout_valid=0 for exactly one cycle, then IDLE.
  - frame_cnt holds its value until the next start.

Latency:
- start sampled at edge N gives the first dout_valid=1 (pattern MSB) after edge N.
- With dout_ready held at 1: a burst takes reps*PAT_W + (reps-1)*gap_len valid cycles, then one DONE cycle.

Boundary conditions:
- start while busy: ignored; latched fields do not change.
- Changes on pattern, reps or gap_len mid-burst have no effect.
- abort=1 in SHIFT, GAP or DONE: next state IDLE, dout_valid=0, no done pulse, frame_cnt keeps its partial count.
- abort and start together in IDLE: start wins, because abort is ignored in IDLE.
- reps = 2^CNT_W-1: frame_cnt must not wrap before the equality test.
- Reset mid-burst takes priority over abort and the handshake.

Decomposition:
- Shared package `seq_pkg`:
  - state encoding constants for IDLE, SHIFT, GAP and DONE, using a 2-bit state register;
  - default PAT_W and CNT_W constants, shared with the sequence detectors.
- One natural sub-module: `piso_shift`, a PAT_W-bit parallel-load, shift-left register with load, shift-enable and MSB-out.
- The FSM, counters and handshake stay in the top level.

Test Plan:
- Single frame:
  - Stimulus: pattern=4'b1011, reps=1, gap_len=0, dout_ready=1.
  - Response: dout = 1,0,1,1 on 4 consecutive valid cycles starting the cycle after start; done pulses once; frame_cnt=1; busy drops after done.
- Back-to-back frames:
  - Stimulus: pattern=4'b1111, reps=3, gap_len=0.
  - Response: 12 contiguous valid 1s; done after the 12th; frame_cnt=3.
  - Feeding the stream into the team's Mealy detector yields the expected number of detections.
- Gapped frames:
  - Stimulus: pattern=4'b1111, reps=2, gap_len=2.
  - Response: 1111 00 1111, i.e. 10 valid cycles, then done; frame_cnt=2.
- Backpressure:
  - Stimulus: pattern=4'b1001, reps=1; dout_ready low on the cycles of bits 1 and 2.
  - Response: dout is held stable while stalled; the accepted sequence is still 1,0,0,1; done is delayed by the stall count.
- Zero-length and ignored start:
  - Stimulus: reps=0.
  - Response: done on the cycle after start; dout_valid never 1; frame_cnt=0.
  - Stimulus: a second start pulse mid-burst.
  - Response: the burst is unchanged.
- Abort and reset:
  - Stimulus: reps=5, abort in frame 3.
  - Response: IDLE next cycle, no done, frame_cnt=2.
  - Stimulus: reset=0 mid-burst.
  - Response: all outputs 0 after that edge.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence transmitter and detectors:
// FSM state encoding and default pattern/count widths.
package seq_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Ready/valid serial bit link between the pattern transmitter and a detector.
interface seq_pattern_tx_if;
  logic dout;
  logic dout_valid;
  logic dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/piso_shift.sv
// Parallel-load, shift-left register; the MSB is the serial output bit.
module piso_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr_q;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift_en) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first for a number
// of frames, with an optional zero-bit gap between frames, over a ready/valid link.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap_len,
  seq_pattern_tx_if.master tx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int IDX_W = $clog2(PAT_W);

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q;
  logic [CNT_W-1:0]   reps_q;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic [CNT_W:0]     frame_inc;
  logic               xfer, last_bit, last_frame, gap_end;
  logic               sh_load, sh_en, sh_msb;
  logic [PAT_W-1:0]   sh_din;

  assign xfer       = (state_q == ST_SHIFT || state_q == ST_GAP) && tx.dout_ready;
  assign last_bit   = (bit_idx_q == IDX_W'(PAT_W - 1));
  // One extra bit so reps = all-ones is reached without wrapping.
  assign frame_inc  = {1'b0, frame_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign last_frame = (frame_inc == {1'b0, reps_q});
  assign gap_end    = (gap_cnt_q == GAP_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (reps != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: begin
        if (abort) state_d = ST_IDLE;
        else if (xfer && last_bit) begin
          if (last_frame)        state_d = ST_DONE;
          else if (gap_q != '0)  state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (abort)                state_d = ST_IDLE;
        else if (xfer && gap_end) state_d = ST_SHIFT;
      end
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Output decode: driven only from registers
  always_comb begin
    tx.dout       = 1'b0;
    tx.dout_valid = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      ST_IDLE:  busy = 1'b0;
      ST_SHIFT: begin
        tx.dout       = sh_msb;
        tx.dout_valid = 1'b1;
      end
      ST_GAP:   tx.dout_valid = 1'b1;
      default:  done = 1'b1;
    endcase
  end

  // Burst fields, counters and bit index
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q       <= '0;
      reps_q      <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      bit_idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          pat_q       <= pattern;
          reps_q      <= reps;
          gap_q       <= gap_len;
          frame_cnt_q <= '0;
          bit_idx_q   <= '0;
        end
        ST_SHIFT: if (!abort && xfer) begin
          bit_idx_q <= last_bit ? '0 : bit_idx_q + IDX_W'(1);
          if (last_bit) begin
            frame_cnt_q <= frame_inc[CNT_W-1:0];
            gap_cnt_q   <= gap_q;
          end
        end
        ST_GAP: if (!abort && xfer) gap_cnt_q <= gap_cnt_q - GAP_W'(1);
        default: ;
      endcase
    end
  end

  // Shift register is loaded from the input on start and from the latched copy on reload.
  always_comb begin
    sh_din  = pat_q;
    sh_load = 1'b0;
    sh_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sh_din  = pattern;
        sh_load = start && (reps != '0);
      end
      ST_SHIFT: begin
        sh_en   = xfer && !abort;
        sh_load = xfer && !abort && last_bit && !last_frame && (gap_q == '0);
      end
      ST_GAP:   sh_load = xfer && !abort && gap_end;
      default: ;
    endcase
  end

  piso_shift #(.W(PAT_W)) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .shift_en (sh_en),
    .din      (sh_din),
    .msb      (sh_msb)
  );

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx with hand-computed bit streams.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort;
  logic [3:0] pattern;
  logic [7:0] reps;
  logic [2:0] gap_len;
  logic       busy, done;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  seq_pattern_tx_if link ();

  seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .reps      (reps),
    .gap_len   (gap_len),
    .tx        (link.master),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sampling and driving happen 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [3:0] p, input logic [7:0] r, input logic [2:0] g);
    pattern = p;
    reps    = r;
    gap_len = g;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Collects accepted bits until done; stall_mask bit c drops ready on cycle c,
  // restart_at pulses a spurious start, abort_at raises abort and returns.
  task automatic collect(input int budget, input logic [63:0] stall_mask,
                         input int restart_at, input int abort_at,
                         output logic [63:0] bits, output int nbits,
                         output int vcycles, output bit saw_done);
    logic prev_stall, prev_dout;
    bits = '0; nbits = 0; vcycles = 0; saw_done = 1'b0;
    prev_stall = 1'b0; prev_dout = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (prev_stall) begin
        check("hold_dout", 64'(link.dout), 64'(prev_dout));
        check("hold_valid", 64'(link.dout_valid), 64'd1);
      end
      link.dout_ready = (c < 64) ? !stall_mask[c[5:0]] : 1'b1;
      if (c == restart_at) begin
        start = 1'b1; pattern = 4'b0110; reps = 8'd7; gap_len = 3'd0;
      end else begin
        start = 1'b0;
      end
      abort = (c == abort_at);
      if (link.dout_valid) vcycles++;
      if (link.dout_valid && link.dout_ready) begin
        bits = {bits[62:0], link.dout};
        nbits++;
      end
      prev_stall = link.dout_valid && !link.dout_ready;
      prev_dout  = link.dout;
      step();
      if (c == abort_at) break;
    end
    start = 1'b0;
    abort = 1'b0;
    link.dout_ready = 1'b1;
  endtask

  logic [63:0] bits;
  int          nbits, vcyc;
  bit          got_done;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; reps = '0; gap_len = '0;
    link.dout_ready = 1'b1;
    step(); step();
    check("rst_dout", 64'(link.dout), 0);
    check("rst_valid", 64'(link.dout_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_fcnt", 64'(frame_cnt), 0);
    reset = 1'b1;
    step();

    // Single frame 1011
    start_burst(4'b1011, 8'd1, 3'd0);
    check("t1_first_valid", 64'(link.dout_valid), 1);
    collect(50, '0, -1, -1, bits, nbits, vcyc, got_done);
    check("t1_done", 64'(got_done), 1);
    check("t1_bits", bits, 64'hB);
    check("t1_nbits", 64'(nbits), 4);
    check("t1_vcyc", 64'(vcyc), 4);
    check("t1_fcnt", 64'(frame_cnt), 1);
    step();
    check("t1_busy_after", 64'(busy), 0);
    check("t1_done_pulse", 64'(done), 0);

    // Back-to-back frames 1111 x3
    start_burst(4'b1111, 8'd3, 3'd0);
    collect(50, '0, -1, -1, bits, nbits, vcyc, got_done);
    check("t2_done", 64'(got_done), 1);
    check("t2_bits", bits, 64'hFFF);
    check("t2_vcyc", 64'(vcyc), 12);
    check("t2_fcnt", 64'(frame_cnt), 3);
    step();

    // Gapped frames: 1111 00 1111
    start_burst(4'b1111, 8'd2, 3'd2);
    collect(50, '0, -1, -1, bits, nbits, vcyc, got_done);
    check("t3_done", 64'(got_done), 1);
    check("t3_bits", bits, 64'h3CF);
    check("t3_nbits", 64'(nbits), 10);
    check("t3_vcyc", 64'(vcyc), 10);
    check("t3_fcnt", 64'(frame_cnt), 2);
    step();

    // Backpressure: bit 1 stalled for two cycles
    start_burst(4'b1001, 8'd1, 3'd0);
    collect(50, 64'b110, -1, -1, bits, nbits, vcyc, got_done);
    check("t4_done", 64'(got_done), 1);
    check("t4_bits", bits, 64'h9);
    check("t4_nbits", 64'(nbits), 4);
    check("t4_vcyc", 64'(vcyc), 6);
    step();

    // Zero-length burst
    start_burst(4'b1111, 8'd0, 3'd0);
    check("t5_done", 64'(done), 1);
    check("t5_valid", 64'(link.dout_valid), 0);
    check("t5_fcnt", 64'(frame_cnt), 0);
    step();
    check("t5_idle", 64'(busy), 0);

    // Spurious start mid-burst: 1011 0 1011
    start_burst(4'b1011, 8'd2, 3'd1);
    collect(50, '0, 3, -1, bits, nbits, vcyc, got_done);
    check("t6_done", 64'(got_done), 1);
    check("t6_bits", bits, 64'h16B);
    check("t6_nbits", 64'(nbits), 9);
    check("t6_fcnt", 64'(frame_cnt), 2);
    step();

    // Abort in frame 3 (frames are 4 bits + 1 gap cycle)
    start_burst(4'b1010, 8'd5, 3'd1);
    collect(50, '0, -1, 11, bits, nbits, vcyc, got_done);
    check("t7_busy", 64'(busy), 0);
    check("t7_valid", 64'(link.dout_valid), 0);
    check("t7_done", 64'(done), 0);
    check("t7_fcnt", 64'(frame_cnt), 2);
    step();
    check("t7_no_late_done", 64'(done), 0);

    // Reset mid-burst beats abort and handshake
    start_burst(4'b1111, 8'd3, 3'd0);
    step(); step(); step(); step(); step();
    check("t8_pre_fcnt", 64'(frame_cnt), 1);
    reset = 1'b0; abort = 1'b1;
    step();
    check("t8_dout", 64'(link.dout), 0);
    check("t8_valid", 64'(link.dout_valid), 0);
    check("t8_busy", 64'(busy), 0);
    check("t8_done", 64'(done), 0);
    check("t8_fcnt", 64'(frame_cnt), 0);
    reset = 1'b1; abort = 1'b0;
    step();

    // Start and abort together in IDLE: start wins
    abort = 1'b1;
    start_burst(4'b1100, 8'd1, 3'd0);
    abort = 1'b0;
    check("t9_busy", 64'(busy), 1);
    check("t9_dout", 64'(link.dout), 1);
    collect(50, '0, -1, -1, bits, nbits, vcyc, got_done);
    check("t9_done", 64'(got_done), 1);
    check("t9_bits", bits, 64'hC);
    step();

    // Maximum repeat count
    start_burst(4'b1001, 8'd255, 3'd0);
    collect(2000, '0, -1, -1, bits, nbits, vcyc, got_done);
    check("t10_done", 64'(got_done), 1);
    check("t10_vcyc", 64'(vcyc), 1020);
    check("t10_fcnt", 64'(frame_cnt), 255);
    step();
    check("t10_idle", 64'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
